// File: rtl/core0_pkg.sv
// Shared types for the core0 data-counter (DC) state slice.
//
// Contents:
//   NUM_DCS         number of DC channels (4)
//   dc_idx_t        DC channel index
//   DC_ADDR_W_MAX   widest DC/memory address a reload entry can carry
//   DC_WORD_W_MAX   widest memory word a reload entry can carry
//   reload_entry_t  one slot of the in-flight reload pipeline
//
// The entry struct is sized to the maximum supported widths so one type
// serves every instantiation. Users zero-extend narrower addresses and data
// into it, so full-width field compares stay exact.
package core0_pkg;

  localparam int NUM_DCS       = 4;
  localparam int DC_ADDR_W_MAX = 32;
  localparam int DC_WORD_W_MAX = 64;

  typedef logic [1:0] dc_idx_t;

  typedef struct packed {
    logic                     valid;   // slot holds a read in flight
    dc_idx_t                  idx;     // destination DC
    logic [DC_ADDR_W_MAX-1:0] addr;    // address captured at issue
    logic                     ovr;     // a later write hit this address
    logic [DC_WORD_W_MAX-1:0] ovr_val; // data of the most recent such write
  } reload_entry_t;

endpackage

// File: rtl/dc_reload_pipe.sv
// Fixed-latency tracker for main-memory reads issued by DC reloads.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset (clears all slots)
//   push_i              a reload issues this cycle (already gated by advance)
//   push_idx_i          DC index of the issuing reload
//   push_addr_i         read address of the issuing reload
//   write_i             memory write this cycle
//   write_address_i     address of the memory write
//   write_value_i       data of the memory write
//   main_read_value_i   memory read data for the entry in the last slot
//   retire_valid_o      last slot retires into the DC cache this edge
//   retire_idx_o        DC index of the retiring entry
//   retire_data_o       data to store for the retiring entry
//   pending_o           at least one slot holds a read in flight
//
// Slot 0 is the youngest entry. The pipeline shifts every cycle because
// memory latency is fixed; it does not look at the core-pipeline enable.
// MAIN_ADDR_WIDTH and WORD_WIDTH must not exceed DC_ADDR_W_MAX/DC_WORD_W_MAX.
module dc_reload_pipe
  import core0_pkg::*;
#(
  parameter int MAIN_ADDR_WIDTH = 1,
  parameter int WORD_WIDTH      = 32,
  parameter int READ_LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  dc_idx_t                    push_idx_i,
  input  logic [MAIN_ADDR_WIDTH-1:0] push_addr_i,
  input  logic                       write_i,
  input  logic [MAIN_ADDR_WIDTH-1:0] write_address_i,
  input  logic [WORD_WIDTH-1:0]      write_value_i,
  input  logic [WORD_WIDTH-1:0]      main_read_value_i,
  output logic                       retire_valid_o,
  output dc_idx_t                    retire_idx_o,
  output logic [WORD_WIDTH-1:0]      retire_data_o,
  output logic                       pending_o
);

  reload_entry_t pipe_q [READ_LATENCY];
  reload_entry_t pipe_d [READ_LATENCY];

  logic [DC_ADDR_W_MAX-1:0] wr_addr_ext;
  logic [DC_WORD_W_MAX-1:0] wr_val_ext;
  logic                     stale;

  assign wr_addr_ext = DC_ADDR_W_MAX'(write_address_i);
  assign wr_val_ext  = DC_WORD_W_MAX'(write_value_i);

  // Shift with snoop. The pushed entry is never overridden: a write in the
  // issue cycle is ordered by the memory's own read-during-write behaviour.
  always_comb begin
    pipe_d = pipe_q;
    pipe_d[0]         = '0;
    pipe_d[0].valid   = push_i;
    pipe_d[0].idx     = push_idx_i;
    pipe_d[0].addr    = DC_ADDR_W_MAX'(push_addr_i);
    for (int j = 1; j < READ_LATENCY; j++) begin
      pipe_d[j] = pipe_q[j-1];
      if (write_i && pipe_q[j-1].valid && (pipe_q[j-1].addr == wr_addr_ext)) begin
        pipe_d[j].ovr     = 1'b1;
        pipe_d[j].ovr_val = wr_val_ext;
      end
    end
  end

  // A younger read to the same DC (including one issuing now) makes the
  // retiring data stale; the younger read will deliver the current value.
  always_comb begin
    stale = push_i && (push_idx_i == pipe_q[READ_LATENCY-1].idx);
    for (int j = 0; j < READ_LATENCY - 1; j++) begin
      if (pipe_q[j].valid && (pipe_q[j].idx == pipe_q[READ_LATENCY-1].idx)) begin
        stale = 1'b1;
      end
    end
    retire_valid_o = pipe_q[READ_LATENCY-1].valid && !stale;
    retire_idx_o   = pipe_q[READ_LATENCY-1].idx;
    retire_data_o  = pipe_q[READ_LATENCY-1].ovr ?
                     pipe_q[READ_LATENCY-1].ovr_val[WORD_WIDTH-1:0] : main_read_value_i;
    // A write landing on the retire edge is newer than anything memory returned.
    if (write_i && (pipe_q[READ_LATENCY-1].addr == wr_addr_ext)) begin
      retire_data_o = write_value_i;
    end
  end

  always_comb begin
    pending_o = 1'b0;
    for (int j = 0; j < READ_LATENCY; j++) begin
      pending_o = pending_o | pipe_q[j].valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < READ_LATENCY; j++) begin
        pipe_q[j] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

endmodule

// File: rtl/dc_state.sv
// Architectural state for the four data-counter (DC) channels.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   advance               core-pipeline enable for all next-state inputs
//   dc_nexts              next DC addresses (one per DC)
//   dc_next_directions    next direction bits (1 = backward)
//   dc_next_modifies      next modify bits
//   reload, choice        issue a read of dc_nexts[choice] into DC choice
//   write_out             memory write this cycle
//   write_address         address of the memory write
//   write_value           data of the memory write
//   main_read_value       memory read data, READ_LATENCY cycles after issue
//   dcs, dc_directions, dc_modifies   registered DC state
//   dc_values, dc_valids  cached word per DC and its current flag
//   reload_pending        at least one read is in flight
//
// Optional build macro DC_STATE_BYPASS_EN: when defined, the retiring word is
// forwarded combinationally onto dc_values/dc_valids in the retire cycle.
// Otherwise all outputs are registered and retired data appears one cycle
// after the retire edge.
module dc_state
  import core0_pkg::*;
#(
  parameter int MAIN_ADDR_WIDTH = 1,
  parameter int WORD_WIDTH      = 32,
  parameter int READ_LATENCY    = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     advance,
  input  logic [NUM_DCS-1:0][MAIN_ADDR_WIDTH-1:0]  dc_nexts,
  input  logic [NUM_DCS-1:0]                       dc_next_directions,
  input  logic [NUM_DCS-1:0]                       dc_next_modifies,
  input  logic                                     reload,
  input  dc_idx_t                                  choice,
  input  logic                                     write_out,
  input  logic [MAIN_ADDR_WIDTH-1:0]               write_address,
  input  logic [WORD_WIDTH-1:0]                    write_value,
  input  logic [WORD_WIDTH-1:0]                    main_read_value,
  output logic [NUM_DCS-1:0][MAIN_ADDR_WIDTH-1:0]  dcs,
  output logic [NUM_DCS-1:0]                       dc_directions,
  output logic [NUM_DCS-1:0]                       dc_modifies,
  output logic [NUM_DCS-1:0][WORD_WIDTH-1:0]       dc_values,
  output logic [NUM_DCS-1:0]                       dc_valids,
  output logic                                     reload_pending
);

  logic [NUM_DCS-1:0][MAIN_ADDR_WIDTH-1:0] dcs_q;
  logic [NUM_DCS-1:0]                      dirs_q;
  logic [NUM_DCS-1:0]                      mods_q;
  logic [NUM_DCS-1:0][WORD_WIDTH-1:0]      values_q, values_d;
  logic [NUM_DCS-1:0]                      valids_q, valids_d;

  logic                  issue;
  logic                  retire_valid;
  dc_idx_t               retire_idx;
  logic [WORD_WIDTH-1:0] retire_data;

  assign issue = advance && reload;

  dc_reload_pipe #(
    .MAIN_ADDR_WIDTH (MAIN_ADDR_WIDTH),
    .WORD_WIDTH      (WORD_WIDTH),
    .READ_LATENCY    (READ_LATENCY)
  ) u_pipe (
    .clk               (clk),
    .reset             (reset),
    .push_i            (issue),
    .push_idx_i        (choice),
    .push_addr_i       (dc_nexts[choice]),
    .write_i           (write_out),
    .write_address_i   (write_address),
    .write_value_i     (write_value),
    .main_read_value_i (main_read_value),
    .retire_valid_o    (retire_valid),
    .retire_idx_o      (retire_idx),
    .retire_data_o     (retire_data),
    .pending_o         (reload_pending)
  );

  // Order matters: retire, then snoop of current cached words, then the
  // issue clear, so a same-edge issue always leaves the flag low.
  always_comb begin
    values_d = values_q;
    valids_d = valids_q;
    if (retire_valid) begin
      values_d[retire_idx] = retire_data;
      valids_d[retire_idx] = 1'b1;
    end
    if (write_out) begin
      for (int i = 0; i < NUM_DCS; i++) begin
        if (valids_q[i] && (dcs_q[i] == write_address)) begin
          values_d[i] = write_value;
        end
      end
    end
    if (issue) begin
      valids_d[choice] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dcs_q    <= '0;
      dirs_q   <= '0;
      mods_q   <= '0;
      values_q <= '0;
      valids_q <= '0;
    end else begin
      if (advance) begin
        dcs_q  <= dc_nexts;
        dirs_q <= dc_next_directions;
        mods_q <= dc_next_modifies;
      end
      values_q <= values_d;
      valids_q <= valids_d;
    end
  end

  assign dcs           = dcs_q;
  assign dc_directions = dirs_q;
  assign dc_modifies   = mods_q;

`ifdef DC_STATE_BYPASS_EN
  always_comb begin
    dc_values = values_q;
    dc_valids = valids_q;
    if (retire_valid) begin
      dc_values[retire_idx] = retire_data;
      dc_valids[retire_idx] = 1'b1;
    end
  end
`else
  assign dc_values = values_q;
  assign dc_valids = valids_q;
`endif

endmodule

// File: tb/tb_dc_state.sv
// Directed bench for dc_state (registered-output build, READ_LATENCY = 2,
// 8-bit addresses). Inputs change 1 time unit after a rising edge and
// outputs are checked at the same point, i.e. after the edge has settled.
module tb_dc_state;

  localparam int AW = 8;
  localparam int WW = 32;
  localparam int RL = 2;

  logic                  clk;
  logic                  reset;
  logic                  advance;
  logic [3:0][AW-1:0]    dc_nexts;
  logic [3:0]            dc_next_directions;
  logic [3:0]            dc_next_modifies;
  logic                  reload;
  logic [1:0]            choice;
  logic                  write_out;
  logic [AW-1:0]         write_address;
  logic [WW-1:0]         write_value;
  logic [WW-1:0]         main_read_value;
  logic [3:0][AW-1:0]    dcs;
  logic [3:0]            dc_directions;
  logic [3:0]            dc_modifies;
  logic [3:0][WW-1:0]    dc_values;
  logic [3:0]            dc_valids;
  logic                  reload_pending;

  int n_cmp  = 0;
  int n_fail = 0;

  dc_state #(
    .MAIN_ADDR_WIDTH (AW),
    .WORD_WIDTH      (WW),
    .READ_LATENCY    (RL)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .advance            (advance),
    .dc_nexts           (dc_nexts),
    .dc_next_directions (dc_next_directions),
    .dc_next_modifies   (dc_next_modifies),
    .reload             (reload),
    .choice             (choice),
    .write_out          (write_out),
    .write_address      (write_address),
    .write_value        (write_value),
    .main_read_value    (main_read_value),
    .dcs                (dcs),
    .dc_directions      (dc_directions),
    .dc_modifies        (dc_modifies),
    .dc_values          (dc_values),
    .dc_valids          (dc_valids),
    .reload_pending     (reload_pending)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic issue(input logic [1:0] ch);
    reload = 1'b1;
    choice = ch;
  endtask

  initial begin
    reset              = 1'b1;
    advance            = 1'b0;
    dc_nexts           = '0;
    dc_next_directions = '0;
    dc_next_modifies   = '0;
    reload             = 1'b0;
    choice             = '0;
    write_out          = 1'b0;
    write_address      = '0;
    write_value        = '0;
    main_read_value    = '0;
    tick();
    tick();

    // Reset state
    chk("rst_dcs",     dcs, 0);
    chk("rst_dirs",    dc_directions, 0);
    chk("rst_mods",    dc_modifies, 0);
    chk("rst_values",  dc_values, 0);
    chk("rst_valids",  dc_valids, 0);
    chk("rst_pending", reload_pending, 0);
    reset = 1'b0;

    // Reset while a read to DC2 is in flight
    dc_nexts           = {8'h20, 8'h10, 8'h05, 8'h08};
    dc_next_directions = 4'b1010;
    dc_next_modifies   = 4'b0110;
    advance            = 1'b1;
    issue(2);
    tick();
    chk("rmf_pending_set", reload_pending, 1);
    reload = 1'b0;
    reset  = 1'b1;
    tick();
    reset           = 1'b0;
    main_read_value = 32'hDEAD;
    tick();
    tick();
    chk("rmf_valids",  dc_valids, 4'b0000);
    chk("rmf_value2",  dc_values[2], 0);
    chk("rmf_pending", reload_pending, 0);
    chk("arch_dcs",    dcs, 32'h20100508);
    chk("arch_dirs",   dc_directions, 4'b1010);
    chk("arch_mods",   dc_modifies, 4'b0110);

    // Basic reload into DC1; data only valid in the second cycle after issue
    main_read_value = '0;
    issue(1);
    tick();
    reload          = 1'b0;
    main_read_value = 32'h1111;
    chk("basic_valid_issue", dc_valids[1], 0);
    chk("basic_pending",     reload_pending, 1);
    tick();
    main_read_value = 32'hCAFE;
    chk("basic_valid_mid", dc_valids[1], 0);
    tick();
    chk("basic_value",   dc_values[1], 32'hCAFE);
    chk("basic_valids",  dc_valids, 4'b0010);
    chk("basic_pend_dn", reload_pending, 0);

    // Reload of a valid DC drops its flag on the issue edge
    main_read_value = '0;
    issue(1);
    tick();
    reload = 1'b0;
    chk("fall_valids", dc_valids, 4'b0000);
    chk("fall_value",  dc_values[1], 32'hCAFE);
    tick();
    main_read_value = 32'hBEEF;
    tick();
    chk("fall_reload_value", dc_values[1], 32'hBEEF);
    chk("fall_reload_valid", dc_valids, 4'b0010);

    // Back-to-back reloads into DC0: first return is stale
    main_read_value = '0;
    issue(0);
    tick();
    issue(0);
    tick();
    reload          = 1'b0;
    main_read_value = 32'hA;
    chk("b2b_valid_c2", dc_valids, 4'b0010);
    tick();
    main_read_value = 32'hB;
    chk("b2b_stale_valid", dc_valids, 4'b0010);
    chk("b2b_stale_value", dc_values[0], 0);
    tick();
    chk("b2b_value", dc_values[0], 32'hB);
    chk("b2b_valid", dc_valids, 4'b0011);

    // Write to the address of an in-flight read overrides memory data
    main_read_value = '0;
    issue(3);
    tick();
    reload        = 1'b0;
    write_out     = 1'b1;
    write_address = 8'h20;
    write_value   = 32'h77;
    tick();
    write_out       = 1'b0;
    main_read_value = 32'h11;
    tick();
    chk("snoop_fly_value", dc_values[3], 32'h77);
    chk("snoop_fly_valid", dc_valids, 4'b1011);

    // Write on the retire edge beats the returned data
    main_read_value = '0;
    issue(2);
    tick();
    reload = 1'b0;
    tick();
    write_out       = 1'b1;
    write_address   = 8'h10;
    write_value     = 32'h55;
    main_read_value = 32'h33;
    tick();
    write_out = 1'b0;
    chk("snoop_ret_value", dc_values[2], 32'h55);
    chk("snoop_ret_valid", dc_valids, 4'b1111);

    // Write in the issue cycle updates the cached word but not the new read
    main_read_value = '0;
    issue(2);
    write_out     = 1'b1;
    write_address = 8'h10;
    write_value   = 32'h66;
    tick();
    reload    = 1'b0;
    write_out = 1'b0;
    chk("issue_wr_valids", dc_valids, 4'b1011);
    chk("issue_wr_cached", dc_values[2], 32'h66);
    tick();
    main_read_value = 32'h44;
    tick();
    chk("issue_wr_value", dc_values[2], 32'h44);
    chk("issue_wr_valid", dc_valids, 4'b1111);

    // Cached-value snoop: DC0 at 0x08 is hit, DC1 moved to 0x09 is not
    main_read_value = '0;
    dc_nexts        = {8'h20, 8'h10, 8'h09, 8'h08};
    tick();
    chk("snoop_c_dcs", dcs, 32'h20100908);
    write_out     = 1'b1;
    write_address = 8'h08;
    write_value   = 32'h99;
    tick();
    write_out = 1'b0;
    chk("snoop_c_hit",  dc_values[0], 32'h99);
    chk("snoop_c_miss", dc_values[1], 32'hBEEF);

    // Stall: nothing architectural moves and no read is issued
    advance            = 1'b0;
    dc_nexts           = {4{8'hAA}};
    dc_next_directions = 4'b0101;
    dc_next_modifies   = 4'b1001;
    issue(2);
    tick();
    chk("stall_dcs",     dcs, 32'h20100908);
    chk("stall_dirs",    dc_directions, 4'b1010);
    chk("stall_mods",    dc_modifies, 4'b0110);
    chk("stall_valids",  dc_valids, 4'b1111);
    chk("stall_pending", reload_pending, 0);
    tick();
    chk("stall_pending2", reload_pending, 0);
    chk("stall_value2",   dc_values[2], 32'h44);
    reload = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
